// File: rtl/bicycle_pkg.sv
// Shared definitions for the bicycle computer blocks: wheel-emulator FSM
// states, common counter widths and the minimum-period helper.
package bicycle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BOUNCE,
    ST_HIGH,
    ST_LOW
  } reed_state_t;

  localparam int REV_WIDTH  = 14;
  localparam int DIST_WIDTH = 14;

  // Shortest legal revolution: bounce chatter, solid closure, and at least
  // one open cycle so consecutive closures stay distinguishable.
  function automatic int minp(input int bounce_cycles, input int pulse_cycles);
    return bounce_cycles + pulse_cycles + 1;
  endfunction

endpackage

// File: rtl/reed_pulse_gen.sv
// Wheel emulator: converts a commanded revolution period (clock cycles) into
// a periodic reed-contact waveform with optional leading contact bounce, and
// counts the revolutions it has emitted (saturating).
module reed_pulse_gen #(
  parameter int PERIOD_WIDTH  = 16,
  parameter int PULSE_CYCLES  = 3,
  parameter int BOUNCE_CYCLES = 0,
  parameter int REV_WIDTH     = bicycle_pkg::REV_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    load,
  output logic                    load_ack,
  output logic                    load_err,
  output logic                    reed,
  output logic [REV_WIDTH-1:0]    rev_count,
  output logic                    running
);
  import bicycle_pkg::*;

  // Cycle positions within a revolution (cnt runs 1..active).
  localparam logic [PERIOD_WIDTH-1:0] BOUNCE_END = PERIOD_WIDTH'(BOUNCE_CYCLES);
  localparam logic [PERIOD_WIDTH-1:0] HIGH_END   = PERIOD_WIDTH'(BOUNCE_CYCLES + PULSE_CYCLES);
  localparam logic [PERIOD_WIDTH-1:0] MIN_PERIOD = PERIOD_WIDTH'(minp(BOUNCE_CYCLES, PULSE_CYCLES));
  localparam logic [REV_WIDTH-1:0]    REV_MAX    = '1;
  localparam logic [PERIOD_WIDTH-1:0] CNT_ONE    = PERIOD_WIDTH'(1);

  reed_state_t               state, state_n;
  logic [PERIOD_WIDTH-1:0]   cnt, cnt_n;
  logic [PERIOD_WIDTH-1:0]   active, active_n;
  logic [PERIOD_WIDTH-1:0]   pending, pending_n;
  logic                      pending_valid, pending_valid_n;
  logic                      reed_n;
  logic [REV_WIDTH-1:0]      rev_count_n;
  logic                      load_ack_n, load_err_n;
  logic                      start;
  logic [PERIOD_WIDTH-1:0]   start_period;

  assign running = (state != ST_IDLE);

  // Register all FSM and datapath state; reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      reed          <= 1'b0;
      rev_count     <= '0;
      load_ack      <= 1'b0;
      load_err      <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      active        <= active_n;
      pending       <= pending_n;
      pending_valid <= pending_valid_n;
      reed          <= reed_n;
      rev_count     <= rev_count_n;
      load_ack      <= load_ack_n;
      load_err      <= load_err_n;
    end
  end

  // Next-state logic: revolution sequencing, bounce shaping, period loading.
  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    active_n        = active;
    pending_n       = pending;
    pending_valid_n = pending_valid;
    reed_n          = reed;
    rev_count_n     = rev_count;
    load_ack_n      = 1'b0;
    load_err_n      = 1'b0;
    start           = 1'b0;
    start_period    = active;

    unique case (state)
      ST_IDLE: begin
        if (enable && pending_valid && (pending != '0)) begin
          start           = 1'b1;
          start_period    = pending;
          pending_valid_n = 1'b0;
        end
      end

      ST_BOUNCE: begin
        cnt_n = cnt + CNT_ONE;
        if (cnt == BOUNCE_END) begin
          state_n = ST_HIGH;
          reed_n  = 1'b1;
        end else begin
          reed_n  = ~reed;
        end
      end

      ST_HIGH: begin
        cnt_n = cnt + CNT_ONE;
        if (cnt == HIGH_END) begin
          state_n = ST_LOW;
          reed_n  = 1'b0;
        end
      end

      ST_LOW: begin
        if (cnt == active) begin
          // Revolution boundary: decisions use pending as it stood before
          // this edge; a load on this same edge lands for the next boundary.
          if (!enable) begin
            state_n = ST_IDLE;
          end else if (pending_valid) begin
            pending_valid_n = 1'b0;
            if (pending == '0) begin
              state_n = ST_IDLE;
            end else begin
              start        = 1'b1;
              start_period = pending;
            end
          end else begin
            start        = 1'b1;
            start_period = active;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    if (start) begin
      active_n = start_period;
      cnt_n    = CNT_ONE;
      reed_n   = 1'b1;
      state_n  = (BOUNCE_CYCLES > 0) ? ST_BOUNCE : ST_HIGH;
      if (rev_count != REV_MAX) begin
        rev_count_n = rev_count + 1'b1;
      end
    end

    // Zero is a legal "stop" request; anything else must fit a full waveform.
    if (load) begin
      if ((period == '0) || (period >= MIN_PERIOD)) begin
        pending_n       = period;
        pending_valid_n = 1'b1;
        load_ack_n      = 1'b1;
      end else begin
        load_err_n      = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reed_pulse_gen.sv
// Testbench for reed_pulse_gen: two instances (no bounce / 14-bit count, and
// 4-cycle bounce / 3-bit count) compared every cycle against a
// revolution-level reference model, with directed steps then random traffic.
module tb_reed_pulse_gen;

  logic        clock = 1'b0;
  logic        reset_i  [2];
  logic        enable_i [2];
  logic [15:0] period_i [2];
  logic        load_i   [2];

  logic        ack0, err0, reed0, run0;
  logic [13:0] rc0;
  logic        ack1, err1, reed1, run1;
  logic [2:0]  rc1;

  int total = 0;
  int bad   = 0;

  // reference model state, per instance
  int BC   [2] = '{0, 4};
  int PC   [2] = '{3, 3};
  int RMAX [2] = '{16383, 7};
  int m_pend [2];
  bit m_pv   [2];
  int m_act  [2];
  int m_len  [2];   // 0 = idle, else length of current revolution
  int m_pos  [2];   // 0-based cycle position within the revolution
  int m_rev  [2];
  bit m_ack  [2];
  bit m_err  [2];

  always #5 clock = ~clock;

  reed_pulse_gen #(.PERIOD_WIDTH(16), .PULSE_CYCLES(3), .BOUNCE_CYCLES(0), .REV_WIDTH(14)) u0 (
    .clock(clock), .reset(reset_i[0]), .enable(enable_i[0]), .period(period_i[0]),
    .load(load_i[0]), .load_ack(ack0), .load_err(err0), .reed(reed0),
    .rev_count(rc0), .running(run0));

  reed_pulse_gen #(.PERIOD_WIDTH(16), .PULSE_CYCLES(3), .BOUNCE_CYCLES(4), .REV_WIDTH(3)) u1 (
    .clock(clock), .reset(reset_i[1]), .enable(enable_i[1]), .period(period_i[1]),
    .load(load_i[1]), .load_ack(ack1), .load_err(err1), .reed(reed1),
    .rev_count(rc1), .running(run1));

  // waveform of a revolution: chatter starting high, solid closure, then open
  function automatic bit pat(int d, int pos);
    if (pos < BC[d]) return (pos % 2) == 0;
    return pos < (BC[d] + PC[d]);
  endfunction

  task automatic model_edge(int d);
    int sv;
    bit was_run;
    if (reset_i[d]) begin
      m_pend[d] = 0; m_pv[d] = 0; m_act[d] = 0; m_len[d] = 0; m_pos[d] = 0;
      m_rev[d] = 0; m_ack[d] = 0; m_err[d] = 0;
      return;
    end
    m_ack[d] = 0;
    m_err[d] = 0;
    was_run = (m_len[d] > 0);
    if (was_run) m_pos[d]++;
    if (!was_run || m_pos[d] >= m_len[d]) begin
      sv = 0;
      if (!was_run) begin
        if (enable_i[d] && m_pv[d] && m_pend[d] != 0) begin
          sv = m_pend[d];
          m_pv[d] = 0;
        end
      end else if (enable_i[d]) begin
        if (m_pv[d]) begin
          m_pv[d] = 0;
          sv = m_pend[d];
        end else begin
          sv = m_act[d];
        end
      end
      if (sv != 0) begin
        m_act[d] = sv;
        m_len[d] = sv;
        m_pos[d] = 0;
        if (m_rev[d] < RMAX[d]) m_rev[d]++;
      end else begin
        m_len[d] = 0;
        m_pos[d] = 0;
      end
    end
    if (load_i[d]) begin
      if (period_i[d] == 0 || int'(period_i[d]) >= BC[d] + PC[d] + 1) begin
        m_pend[d] = int'(period_i[d]);
        m_pv[d]   = 1;
        m_ack[d]  = 1;
      end else begin
        m_err[d]  = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_reed(int d);
    return (m_len[d] > 0) ? pat(d, m_pos[d]) : 1'b0;
  endfunction

  task automatic tick();
    @(posedge clock);
    model_edge(0);
    model_edge(1);
    #1;
    chk("reed0", {31'b0, reed0}, {31'b0, exp_reed(0)});
    chk("run0",  {31'b0, run0},  {31'b0, m_len[0] > 0});
    chk("ack0",  {31'b0, ack0},  {31'b0, m_ack[0]});
    chk("err0",  {31'b0, err0},  {31'b0, m_err[0]});
    chk("rev0",  {18'b0, rc0},   m_rev[0]);
    chk("reed1", {31'b0, reed1}, {31'b0, exp_reed(1)});
    chk("run1",  {31'b0, run1},  {31'b0, m_len[1] > 0});
    chk("ack1",  {31'b0, ack1},  {31'b0, m_ack[1]});
    chk("err1",  {31'b0, err1},  {31'b0, m_err[1]});
    chk("rev1",  {29'b0, rc1},   m_rev[1]);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_load(int d, int val);
    load_i[d]   = 1'b1;
    period_i[d] = 16'(val);
    tick();
    load_i[d]   = 1'b0;
  endtask

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      reset_i[d] = 1'b1; enable_i[d] = 1'b0; period_i[d] = '0; load_i[d] = 1'b0;
    end
    run(2);
    reset_i[0] = 1'b0;
    reset_i[1] = 1'b0;
    run(1);
    chk("rst_reed",  {31'b0, reed0}, 0);
    chk("rst_rev",   {18'b0, rc0},   0);
    chk("rst_run",   {31'b0, run0},  0);
    chk("rst_ack",   {31'b0, ack0},  0);

    // steady 10-cycle revolutions
    enable_i[0] = 1'b1;
    pulse_load(0, 10);
    chk("t1_ack", {31'b0, ack0}, 1);
    run(1);
    chk("t1_first_reed", {31'b0, reed0}, 1);
    run(40);

    // too-short period rejected
    pulse_load(0, 3);
    chk("t2_err", {31'b0, err0}, 1);
    chk("t2_noack", {31'b0, ack0}, 0);
    run(12);

    // load landing exactly on a revolution boundary edge
    n = 0;
    while (!(m_len[0] > 0 && m_pos[0] == m_len[0] - 1) && n < 100) begin tick(); n++; end
    chk("t3_wait", {31'b0, n < 100}, 1);
    pulse_load(0, 20);
    run(60);

    // enable dropped during the closure
    n = 0;
    while (!(m_len[0] > 0 && m_pos[0] == 1) && n < 100) begin tick(); n++; end
    chk("t4_wait", {31'b0, n < 100}, 1);
    enable_i[0] = 1'b0;
    run(30);
    chk("t4_idle_run",  {31'b0, run0},  0);
    chk("t4_idle_reed", {31'b0, reed0}, 0);
    enable_i[0] = 1'b1;
    pulse_load(0, 10);
    run(25);

    // bounce instance: pattern, rejects below MINP=8, saturation, stop
    enable_i[1] = 1'b1;
    pulse_load(1, 12);
    pulse_load(1, 7);
    pulse_load(1, 4);
    run(120);
    chk("t6_sat", {29'b0, rc1}, 7);
    pulse_load(1, 8);
    run(20);
    n = 0;
    while (!(m_len[1] > 0 && m_pos[1] >= 1 && m_pos[1] < 4) && n < 100) begin tick(); n++; end
    chk("t6_wait", {31'b0, n < 100}, 1);
    reset_i[1] = 1'b1;
    tick();
    reset_i[1] = 1'b0;
    chk("t6_rst_reed", {31'b0, reed1}, 0);
    chk("t6_rst_rev",  {29'b0, rc1},   0);
    chk("t6_rst_run",  {31'b0, run1},  0);
    enable_i[1] = 1'b1;
    pulse_load(1, 9);
    run(30);
    pulse_load(1, 0);
    run(30);

    // random traffic on both instances
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 14) == 0) begin
          load_i[d]   = 1'b1;
          period_i[d] = 16'($urandom_range(0, 25));
        end
        if ($urandom_range(0, 39) == 0) enable_i[d] = ~enable_i[d];
        if ($urandom_range(0, 249) == 0) reset_i[d] = 1'b1;
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        load_i[d]  = 1'b0;
        reset_i[d] = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
